// File: rtl/din_debounce.sv
// Synchroniser plus stability-counter debouncer for an asynchronous level input.
// Optional rejected-transition counter enabled by DIN_DEBOUNCE_GLITCH_CNT_EN.
module din_debounce #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_W         = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        din_raw,
  output logic        dout,
  output logic        changed,
  output logic        busy
`ifdef DIN_DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic [15:0] glitch_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE_LOW   = 2'd0,
    CHECK_HIGH = 2'd1,
    IDLE_HIGH  = 2'd2,
    CHECK_LOW  = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s;
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   dout_q, dout_d;
  logic                   changed_q, changed_d;
  logic                   busy_q, busy_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din_raw};
  end

  assign s = sync_q[SYNC_STAGES-1];

  // cnt counts agreeing samples already seen; the sample that makes it reach
  // STABLE_CYCLES commits, so the compare is against STABLE_CYCLES-1.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dout_d    = dout_q;
    changed_d = 1'b0;
    case (state_q)
      IDLE_LOW: begin
        if (s) begin
          state_d = CHECK_HIGH;
          cnt_d   = CNT_ONE;
        end
      end
      CHECK_HIGH: begin
        if (!s) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = IDLE_HIGH;
          dout_d    = 1'b1;
          changed_d = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      IDLE_HIGH: begin
        if (!s) begin
          state_d = CHECK_LOW;
          cnt_d   = CNT_ONE;
        end
      end
      CHECK_LOW: begin
        if (s) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = IDLE_LOW;
          dout_d    = 1'b0;
          changed_d = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE_LOW;
        cnt_d   = '0;
        dout_d  = 1'b0;
      end
    endcase
    busy_d = (state_d == CHECK_HIGH) || (state_d == CHECK_LOW);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q    <= '0;
      state_q   <= IDLE_LOW;
      cnt_q     <= '0;
      dout_q    <= 1'b0;
      changed_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dout_q    <= dout_d;
      changed_q <= changed_d;
      busy_q    <= busy_d;
    end
  end

  assign dout    = dout_q;
  assign changed = changed_q;
  assign busy    = busy_q;

`ifdef DIN_DEBOUNCE_GLITCH_CNT_EN
  logic [15:0] glitch_q, glitch_d;
  logic        abort;

  // Any CHECK state falling back to its idle state is a rejected transition.
  always_comb begin
    abort    = ((state_q == CHECK_HIGH) && !s) || ((state_q == CHECK_LOW) && s);
    glitch_d = glitch_q;
    if (abort && (glitch_q != 16'hFFFF)) glitch_d = glitch_q + 16'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) glitch_q <= '0;
    else         glitch_q <= glitch_d;
  end

  assign glitch_cnt = glitch_q;
`endif

endmodule
